// File: rtl/fft_stage_radix2.sv
// fft_stage_radix2: one radix-2 DIT butterfly stage.
// Reads a ping-pong bank plus twiddle ROM; writes the other bank.
module fft_stage_radix2 #(
  parameter int DATA_W = 32,
  parameter int LOG2N  = 10,
  parameter int STAGE  = 6,
  parameter int TW_W   = 16,
  parameter int SCALE  = 0
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  input  logic              ap_continue,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic              inverse,
  output logic [LOG2N-1:0]  X_R_address0,
  output logic              X_R_ce0,
  input  logic [DATA_W-1:0] X_R_q0,
  output logic [LOG2N-1:0]  X_I_address0,
  output logic              X_I_ce0,
  input  logic [DATA_W-1:0] X_I_q0,
  output logic [LOG2N-2:0]  Tw_address0,
  output logic              Tw_ce0,
  input  logic [TW_W-1:0]   Tw_R_q0,
  input  logic [TW_W-1:0]   Tw_I_q0,
  output logic [LOG2N-1:0]  Out_R_address0,
  output logic              Out_R_ce0,
  output logic              Out_R_we0,
  output logic [DATA_W-1:0] Out_R_d0,
  output logic [LOG2N-1:0]  Out_R_address1,
  output logic              Out_R_ce1,
  output logic              Out_R_we1,
  output logic [DATA_W-1:0] Out_R_d1,
  output logic [LOG2N-1:0]  Out_I_address0,
  output logic              Out_I_ce0,
  output logic              Out_I_we0,
  output logic [DATA_W-1:0] Out_I_d0,
  output logic [LOG2N-1:0]  Out_I_address1,
  output logic              Out_I_ce1,
  output logic              Out_I_we1,
  output logic [DATA_W-1:0] Out_I_d1
);

  localparam int BW = LOG2N - 1;
  localparam int PW = DATA_W + TW_W + 2;
  localparam int TSH = LOG2N - STAGE;
  localparam logic [BW-1:0] BLAST = '1;
  localparam logic [LOG2N-1:0] HSPAN =
    LOG2N'(64'd1 << (STAGE - 1));
  localparam logic [LOG2N-1:0] HMASK = HSPAN - 1'b1;
  localparam logic signed [PW-1:0] RND =
    PW'(64'd1 << (TW_W - 2));

  localparam int I_IDLE = 0;
  localparam int I_RDB  = 1;
  localparam int I_RDT  = 2;
  localparam int I_MUL  = 3;
  localparam int I_WR   = 4;
  localparam int I_FIN  = 5;

  typedef enum logic [5:0] {
    S_IDLE = 6'b000001,
    S_RDB  = 6'b000010,
    S_RDT  = 6'b000100,
    S_MUL  = 6'b001000,
    S_WR   = 6'b010000,
    S_FIN  = 6'b100000
  } state_t;

  state_t state_q, state_d;
  logic [BW-1:0] b_q, b_d;
  logic done_q, done_d;
  logic inv_q, inv_d;

  logic [DATA_W-1:0] br_q, bi_q;
  logic [DATA_W-1:0] xtr_q, xti_q;
  logic [DATA_W-1:0] tr_q, ti_q;
  logic [TW_W-1:0] wr_q;
  logic [TW_W:0] wi_q;

  logic st_idle, st_rdb, st_rdt;
  logic st_mul, st_wr, st_fin;

  assign st_idle = state_q[I_IDLE];
  assign st_rdb  = state_q[I_RDB];
  assign st_rdt  = state_q[I_RDT];
  assign st_mul  = state_q[I_MUL];
  assign st_wr   = state_q[I_WR];
  assign st_fin  = state_q[I_FIN];

  // Butterfly index decode: span-H pairs and twiddle index.
  logic [LOG2N-1:0] b_ext, k_w, top_w, bot_w;
  assign b_ext = {1'b0, b_q};
  assign k_w   = b_ext & HMASK;
  assign top_w = ((b_ext >> (STAGE - 1)) << STAGE) | k_w;
  assign bot_w = top_w | HSPAN;

  logic [TW_W:0] wi_ext, wi_nxt;
  assign wi_ext = {Tw_I_q0[TW_W-1], Tw_I_q0};
  assign wi_nxt = inv_q ? -wi_ext : wi_ext;

  // Complex multiply with round-half-up back to Q(DATA_W).
  logic signed [PW-1:0] br_x, bi_x, wr_x, wi_x;
  logic signed [PW-1:0] pr, pi;
  logic [DATA_W-1:0] tr_w, ti_w;
  assign br_x = PW'($signed(br_q));
  assign bi_x = PW'($signed(bi_q));
  assign wr_x = PW'($signed(wr_q));
  assign wi_x = PW'($signed(wi_q));
  assign pr = br_x * wr_x - bi_x * wi_x + RND;
  assign pi = br_x * wi_x + bi_x * wr_x + RND;
  assign tr_w = DATA_W'(pr >>> (TW_W - 1));
  assign ti_w = DATA_W'(pi >>> (TW_W - 1));

  // Sums carry one guard bit so the scaled path cannot overflow.
  logic [DATA_W:0] srt, srb, sit, sib;
  logic [DATA_W-1:0] ort, orb, oit, oib;
  assign srt = {xtr_q[DATA_W-1], xtr_q} + {tr_q[DATA_W-1], tr_q};
  assign srb = {xtr_q[DATA_W-1], xtr_q} - {tr_q[DATA_W-1], tr_q};
  assign sit = {xti_q[DATA_W-1], xti_q} + {ti_q[DATA_W-1], ti_q};
  assign sib = {xti_q[DATA_W-1], xti_q} - {ti_q[DATA_W-1], ti_q};
  assign ort = (SCALE != 0) ? srt[DATA_W:1] : srt[DATA_W-1:0];
  assign orb = (SCALE != 0) ? srb[DATA_W:1] : srb[DATA_W-1:0];
  assign oit = (SCALE != 0) ? sit[DATA_W:1] : sit[DATA_W-1:0];
  assign oib = (SCALE != 0) ? sib[DATA_W:1] : sib[DATA_W-1:0];

  // Control state and chain-handshake registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
      b_q     <= '0;
      done_q  <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      done_q  <= done_d;
      inv_q   <= inv_d;
    end
  end

  // Next-state: four cycles per butterfly, done held until continue.
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    done_d  = done_q;
    inv_d   = inv_q;
    if (ap_continue) done_d = 1'b0;
    unique case (1'b1)
      state_q[I_IDLE]: begin
        if (ap_start && !done_q) begin
          state_d = S_RDB;
          b_d     = '0;
          inv_d   = inverse;
        end
      end
      state_q[I_RDB]: state_d = S_RDT;
      state_q[I_RDT]: state_d = S_MUL;
      state_q[I_MUL]: state_d = S_WR;
      state_q[I_WR]: begin
        b_d     = b_q + 1'b1;
        state_d = (b_q == BLAST) ? S_FIN : S_RDB;
      end
      state_q[I_FIN]: begin
        state_d = S_IDLE;
        done_d  = !ap_continue;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture: bottom/twiddle in RD_T, top and product in MUL.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      br_q  <= '0;
      bi_q  <= '0;
      wr_q  <= '0;
      wi_q  <= '0;
      xtr_q <= '0;
      xti_q <= '0;
      tr_q  <= '0;
      ti_q  <= '0;
    end else begin
      if (st_rdt) begin
        br_q <= X_R_q0;
        bi_q <= X_I_q0;
        wr_q <= Tw_R_q0;
        wi_q <= wi_nxt;
      end
      if (st_mul) begin
        xtr_q <= X_R_q0;
        xti_q <= X_I_q0;
        tr_q  <= tr_w;
        ti_q  <= ti_w;
      end
    end
  end

  logic [LOG2N-1:0] xa;
  assign xa = st_rdb ? bot_w : (st_rdt ? top_w : '0);

  assign ap_done  = st_fin | done_q;
  assign ap_ready = st_fin;
  assign ap_idle  = st_idle & !ap_start;

  assign X_R_address0 = xa;
  assign X_I_address0 = xa;
  assign X_R_ce0      = st_rdb | st_rdt;
  assign X_I_ce0      = st_rdb | st_rdt;
  assign Tw_address0  = st_rdb ? BW'(k_w << TSH) : '0;
  assign Tw_ce0       = st_rdb;

  assign Out_R_address0 = st_wr ? top_w : '0;
  assign Out_I_address0 = st_wr ? top_w : '0;
  assign Out_R_address1 = st_wr ? bot_w : '0;
  assign Out_I_address1 = st_wr ? bot_w : '0;
  assign Out_R_ce0 = st_wr;
  assign Out_R_we0 = st_wr;
  assign Out_R_ce1 = st_wr;
  assign Out_R_we1 = st_wr;
  assign Out_I_ce0 = st_wr;
  assign Out_I_we0 = st_wr;
  assign Out_I_ce1 = st_wr;
  assign Out_I_we1 = st_wr;
  assign Out_R_d0 = st_wr ? ort : '0;
  assign Out_R_d1 = st_wr ? orb : '0;
  assign Out_I_d0 = st_wr ? oit : '0;
  assign Out_I_d1 = st_wr ? oib : '0;

endmodule

// File: tb/tb_fft_stage_radix2.sv
// tb_fft_stage_radix2: scoreboard bench over three stage configs.
// Inst 0: stage 1; inst 1: stage 3; inst 2: stage 1 scaled.
module tb_fft_stage_radix2;

  localparam int DW = 16;
  localparam int LN = 3;
  localparam int TW = 16;
  localparam int N  = 8;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_n [NI];
  logic start [NI];
  logic cont  [NI];
  logic inv   [NI];
  logic done  [NI];
  logic idle  [NI];
  logic rdy   [NI];
  logic [LN-1:0] xra [NI];
  logic [LN-1:0] xia [NI];
  logic xrce [NI];
  logic xice [NI];
  logic [DW-1:0] xrq [NI];
  logic [DW-1:0] xiq [NI];
  logic [LN-2:0] twa [NI];
  logic twce [NI];
  logic [TW-1:0] twrq [NI];
  logic [TW-1:0] twiq [NI];
  logic [LN-1:0] ora0 [NI];
  logic [LN-1:0] ora1 [NI];
  logic [LN-1:0] oia0 [NI];
  logic [LN-1:0] oia1 [NI];
  logic orce0 [NI];
  logic orwe0 [NI];
  logic orce1 [NI];
  logic orwe1 [NI];
  logic oice0 [NI];
  logic oiwe0 [NI];
  logic oice1 [NI];
  logic oiwe1 [NI];
  logic [DW-1:0] ord0 [NI];
  logic [DW-1:0] ord1 [NI];
  logic [DW-1:0] oid0 [NI];
  logic [DW-1:0] oid1 [NI];

  logic [DW-1:0] xr_m [NI][N];
  logic [DW-1:0] xi_m [NI][N];
  logic [TW-1:0] twr_m [N/2];
  logic [TW-1:0] twi_m [N/2];

  int start_edge [NI];
  int wr_cnt [NI];
  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    int g;
    int cy;
    logic [LN-1:0] at;
    logic [LN-1:0] ab;
    logic [DW-1:0] tr;
    logic [DW-1:0] ti;
    logic [DW-1:0] br;
    logic [DW-1:0] bi;
  } exp_t;

  exp_t sbq [$];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    fft_stage_radix2 #(
      .DATA_W(DW), .LOG2N(LN),
      .STAGE((g == 1) ? 3 : 1),
      .TW_W(TW),
      .SCALE((g == 2) ? 1 : 0)
    ) u_dut (
      .ap_clk(clk), .ap_rst_n(rst_n[g]),
      .ap_start(start[g]), .ap_continue(cont[g]),
      .ap_done(done[g]), .ap_idle(idle[g]),
      .ap_ready(rdy[g]), .inverse(inv[g]),
      .X_R_address0(xra[g]), .X_R_ce0(xrce[g]),
      .X_R_q0(xrq[g]),
      .X_I_address0(xia[g]), .X_I_ce0(xice[g]),
      .X_I_q0(xiq[g]),
      .Tw_address0(twa[g]), .Tw_ce0(twce[g]),
      .Tw_R_q0(twrq[g]), .Tw_I_q0(twiq[g]),
      .Out_R_address0(ora0[g]), .Out_R_ce0(orce0[g]),
      .Out_R_we0(orwe0[g]), .Out_R_d0(ord0[g]),
      .Out_R_address1(ora1[g]), .Out_R_ce1(orce1[g]),
      .Out_R_we1(orwe1[g]), .Out_R_d1(ord1[g]),
      .Out_I_address0(oia0[g]), .Out_I_ce0(oice0[g]),
      .Out_I_we0(oiwe0[g]), .Out_I_d0(oid0[g]),
      .Out_I_address1(oia1[g]), .Out_I_ce1(oice1[g]),
      .Out_I_we1(oiwe1[g]), .Out_I_d1(oid1[g])
    );
  end

  // Bank and ROM models with one-cycle read latency.
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (xrce[g]) xrq[g] <= xr_m[g][xra[g]];
      if (xice[g]) xiq[g] <= xi_m[g][xia[g]];
      if (twce[g]) begin
        twrq[g] <= twr_m[twa[g]];
        twiq[g] <= twi_m[twa[g]];
      end
    end
  end

  function automatic logic [7:0] ostb(input int g);
    return {orce0[g], orwe0[g], orce1[g], orwe1[g],
            oice0[g], oiwe0[g], oice1[g], oiwe1[g]};
  endfunction

  function automatic logic [7:0] istb(input int g);
    return {xrce[g], xice[g], twce[g], 5'd0};
  endfunction

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic push_bf(input int g, input int n,
                         input int at, input int ab,
                         input int tr, input int ti,
                         input int br, input int bi);
    exp_t e;
    e.g  = g;
    e.cy = 4 * n + 4;
    e.at = LN'(at);
    e.ab = LN'(ab);
    e.tr = DW'(tr);
    e.ti = DW'(ti);
    e.br = DW'(br);
    e.bi = DW'(bi);
    sbq.push_back(e);
  endtask

  // Monitor: every write cycle is matched against the scoreboard.
  always @(negedge clk) begin : mon
    exp_t e;
    for (int g = 0; g < NI; g++) begin
      if (|ostb(g)) begin
        wr_cnt[g]++;
        if (sbq.size() == 0) begin
          chk("unexpected_write", 128'(g), 128'(-1));
        end else begin
          e = sbq.pop_front();
          chk("wr_inst", 128'(g), 128'(e.g));
          chk("wr_cycle", 128'(cyc - start_edge[g] + 1),
              128'(e.cy));
          chk("wr_strobes", 128'(ostb(g)), 128'(8'hFF));
          chk("wr_addr",
              {ora0[g], ora1[g], oia0[g], oia1[g]},
              {e.at, e.ab, e.at, e.ab});
          chk("wr_data",
              {ord0[g], oid0[g], ord1[g], oid1[g]},
              {e.tr, e.ti, e.br, e.bi});
        end
      end
    end
  end

  task automatic run_start(input int g);
    start[g] = 1'b1;
    start_edge[g] = cyc + 1;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g);
    bit seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done[g]) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_cycle",
        seen ? 128'(cyc - start_edge[g] + 1) : 128'(-1),
        128'(2 * N + 1));
    chk("ready_at_fin", 128'(rdy[g]), 128'(1));
  endtask

  task automatic pulse_cont(input int g);
    cont[g] = 1'b1;
    @(negedge clk);
    cont[g] = 1'b0;
    chk("cont_clears_done", 128'(done[g]), 128'(0));
  endtask

  task automatic clr_mem(input int g);
    for (int a = 0; a < N; a++) begin
      xr_m[g][a] = '0;
      xi_m[g][a] = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    twr_m[0] = 16'sd32767;  twi_m[0] = 16'sd0;
    twr_m[1] = 16'sd23170;  twi_m[1] = -16'sd23170;
    twr_m[2] = 16'sd0;      twi_m[2] = -16'sd32767;
    twr_m[3] = -16'sd23170; twi_m[3] = -16'sd23170;
    for (int g = 0; g < NI; g++) begin
      rst_n[g] = 1'b0;
      start[g] = 1'b0;
      cont[g]  = 1'b0;
      inv[g]   = 1'b0;
      wr_cnt[g] = 0;
      start_edge[g] = 0;
      clr_mem(g);
    end
    start[0] = 1'b1;

    // Reset: start held on inst 0, low on inst 1.
    repeat (3) @(negedge clk);
    chk("rst_strobes", 128'({istb(0), ostb(0)}), 128'(0));
    chk("rst_status", 128'({done[0], rdy[0], idle[0]}),
        128'(3'b000));
    chk("rst_idle_nostart", 128'(idle[1]), 128'(1));
    chk("rst_addr_data",
        {xra[0], twa[0], ora0[0], ora1[0],
         ord0[0], ord1[0], oid0[0], oid1[0]},
        128'(0));
    start[0] = 1'b0;
    for (int g = 0; g < NI; g++) rst_n[g] = 1'b1;
    @(negedge clk);

    // Inst 0: forward butterfly plus unscaled wrap.
    xr_m[0][0] = 16'sd1000;
    xr_m[0][1] = 16'sd200;
    xr_m[0][2] = 16'sd32767;
    xr_m[0][3] = 16'sd32767;
    push_bf(0, 0, 0, 1, 1200, 0, 800, 0);
    push_bf(0, 1, 2, 3, -3, 0, 1, 0);
    push_bf(0, 2, 4, 5, 0, 0, 0, 0);
    push_bf(0, 3, 6, 7, 0, 0, 0, 0);
    wr_cnt[0] = 0;
    run_start(0);
    wait_done(0);
    chk("write_count", 128'(wr_cnt[0]), 128'(4));

    // Chain: start held, no continue -> blocked.
    start[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("blocked_done", 128'(done[0]), 128'(1));
      chk("blocked_no_ce", 128'(xrce[0]), 128'(0));
    end
    push_bf(0, 0, 0, 1, 1200, 0, 800, 0);
    push_bf(0, 1, 2, 3, -3, 0, 1, 0);
    push_bf(0, 2, 4, 5, 0, 0, 0, 0);
    push_bf(0, 3, 6, 7, 0, 0, 0, 0);
    start_edge[0] = cyc + 2;
    pulse_cont(0);
    @(negedge clk);
    chk("restart_rdb", 128'(xrce[0]), 128'(1));
    start[0] = 1'b0;
    wait_done(0);
    pulse_cont(0);

    // Mid-run reset: only butterflies 0 and 1 get written.
    push_bf(0, 0, 0, 1, 1200, 0, 800, 0);
    push_bf(0, 1, 2, 3, -3, 0, 1, 0);
    run_start(0);
    repeat (9) @(negedge clk);
    chk("prereset_ce", 128'(xrce[0]), 128'(1));
    rst_n[0] = 1'b0;
    #1;
    chk("midreset_strobes", 128'({istb(0), ostb(0)}), 128'(0));
    chk("midreset_sb_drained", 128'(sbq.size()), 128'(0));
    @(negedge clk);
    rst_n[0] = 1'b1;
    @(negedge clk);
    chk("postreset_idle", 128'({idle[0], done[0]}), 128'(2'b10));
    push_bf(0, 0, 0, 1, 1200, 0, 800, 0);
    push_bf(0, 1, 2, 3, -3, 0, 1, 0);
    push_bf(0, 2, 4, 5, 0, 0, 0, 0);
    push_bf(0, 3, 6, 7, 0, 0, 0, 0);
    run_start(0);
    wait_done(0);
    pulse_cont(0);

    // Inst 1: stage 3 twiddle, forward then inverse.
    xr_m[1][5] = 16'sd1000;
    push_bf(1, 0, 0, 4, 0, 0, 0, 0);
    push_bf(1, 1, 1, 5, 707, -707, -707, 707);
    push_bf(1, 2, 2, 6, 0, 0, 0, 0);
    push_bf(1, 3, 3, 7, 0, 0, 0, 0);
    run_start(1);
    wait_done(1);
    pulse_cont(1);
    push_bf(1, 0, 0, 4, 0, 0, 0, 0);
    push_bf(1, 1, 1, 5, 707, 707, -707, -707);
    push_bf(1, 2, 2, 6, 0, 0, 0, 0);
    push_bf(1, 3, 3, 7, 0, 0, 0, 0);
    inv[1] = 1'b1;
    run_start(1);
    inv[1] = 1'b0;
    wait_done(1);
    pulse_cont(1);

    // Inst 2: scaled outputs, overflow-free and floor rounding.
    xr_m[2][0] = 16'sd32767;
    xr_m[2][1] = 16'sd32767;
    xr_m[2][2] = -16'sd3;
    xr_m[2][3] = 16'sd0;
    push_bf(2, 0, 0, 1, 32766, 0, 0, 0);
    push_bf(2, 1, 2, 3, -2, 0, -2, 0);
    push_bf(2, 2, 4, 5, 0, 0, 0, 0);
    push_bf(2, 3, 6, 7, 0, 0, 0, 0);
    run_start(2);
    wait_done(2);
    pulse_cont(2);

    repeat (3) @(negedge clk);
    chk("sb_empty", 128'(sbq.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
